// File: rtl/cpu_test_sequencer.sv
// cpu_test_sequencer: loads a program and a known register image into the CPU,
// runs it until a halt PC or a cycle budget, then walks a table of register
// checks and reports pass/fail together with the first failing check index.
module cpu_test_sequencer #(
    parameter int N_REGISTERS    = 32,
    parameter int INSTR_MEM_SIZE = 32,
    parameter int N_CHECKS       = 4,
    parameter int MAX_CYCLES     = 64,
    parameter int CNT_W          = 16,
    localparam int AW = (INSTR_MEM_SIZE > 1) ? $clog2(INSTR_MEM_SIZE) : 1,
    localparam int CW = $clog2(N_CHECKS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic [AW-1:0]    prog_addr,
    input  logic [31:0]      prog_data,
    output logic             imem_we,
    output logic [AW-1:0]    imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             reg_we,
    output logic [4:0]       reg_addr,
    output logic [31:0]      reg_wdata,
    input  logic [31:0]      reg_rdata,
    input  logic [31:0]      cpu_pc,
    input  logic [31:0]      halt_pc,
    output logic             cpu_reset,
    output logic             cpu_stall,
    output logic [CW-1:0]    chk_index,
    input  logic [4:0]       chk_reg,
    input  logic [31:0]      chk_value,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CW-1:0]    fail_index,
    output logic [CNT_W-1:0] cycles
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_I, S_LOAD_R, S_RUN, S_CHECK, S_DONE
    } state_t;

    localparam logic [AW-1:0]    LAST_WORD = AW'(INSTR_MEM_SIZE - 1);
    localparam logic [4:0]       LAST_REG  = 5'(N_REGISTERS - 1);
    localparam logic [CW-1:0]    LAST_CHK  = CW'(N_CHECKS - 1);
    localparam logic [CW-1:0]    NO_FAIL   = CW'(N_CHECKS);
    localparam logic [CNT_W-1:0] BUDGET    = CNT_W'(MAX_CYCLES);

    state_t           r_state,      w_state_n;
    logic [AW-1:0]    r_prog_addr,  w_prog_addr_n;
    logic             r_imem_we,    w_imem_we_n;
    logic             r_reg_we,     w_reg_we_n;
    logic [4:0]       r_reg_addr,   w_reg_addr_n;
    logic [31:0]      r_reg_wdata,  w_reg_wdata_n;
    logic             r_cpu_reset,  w_cpu_reset_n;
    logic             r_cpu_stall,  w_cpu_stall_n;
    logic [CW-1:0]    r_chk_index,  w_chk_index_n;
    logic             r_busy,       w_busy_n;
    logic             r_done,       w_done_n;
    logic             r_pass,       w_pass_n;
    logic             r_timeout,    w_timeout_n;
    logic [CW-1:0]    r_fail_index, w_fail_index_n;
    logic [CNT_W-1:0] r_cycles,     w_cycles_n;

    // The ROM word goes straight through so it lines up with the registered address;
    // during CHECK the register port is steered by the check table.
    assign prog_addr  = r_prog_addr;
    assign imem_addr  = r_prog_addr;
    assign imem_wdata = prog_data;
    assign imem_we    = r_imem_we;
    assign reg_we     = r_reg_we;
    assign reg_addr   = (r_state == S_CHECK) ? chk_reg : r_reg_addr;
    assign reg_wdata  = r_reg_wdata;
    assign cpu_reset  = r_cpu_reset;
    assign cpu_stall  = r_cpu_stall;
    assign chk_index  = r_chk_index;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign timeout    = r_timeout;
    assign fail_index = r_fail_index;
    assign cycles     = r_cycles;

    // Next state and next value of every registered output.
    always_comb begin
        w_state_n      = r_state;
        w_prog_addr_n  = r_prog_addr;
        w_imem_we_n    = 1'b0;
        w_reg_we_n     = 1'b0;
        w_reg_addr_n   = r_reg_addr;
        w_reg_wdata_n  = r_reg_wdata;
        w_cpu_reset_n  = r_cpu_reset;
        w_cpu_stall_n  = r_cpu_stall;
        w_chk_index_n  = r_chk_index;
        w_busy_n       = r_busy;
        w_done_n       = r_done;
        w_pass_n       = r_pass;
        w_timeout_n    = r_timeout;
        w_fail_index_n = r_fail_index;
        w_cycles_n     = r_cycles;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_n      = S_LOAD_I;
                    w_prog_addr_n  = '0;
                    w_imem_we_n    = 1'b1;
                    w_cpu_reset_n  = 1'b1;
                    w_cpu_stall_n  = 1'b0;
                    w_chk_index_n  = '0;
                    w_busy_n       = 1'b1;
                    w_done_n       = 1'b0;
                    w_pass_n       = 1'b0;
                    w_timeout_n    = 1'b0;
                    w_fail_index_n = '0;
                    w_cycles_n     = '0;
                end
            end
            S_LOAD_I: begin
                if (r_prog_addr == LAST_WORD) begin
                    w_state_n     = S_LOAD_R;
                    w_reg_we_n    = 1'b1;
                    w_reg_addr_n  = 5'd0;
                    w_reg_wdata_n = 32'd0;
                end else begin
                    w_prog_addr_n = r_prog_addr + AW'(1);
                    w_imem_we_n   = 1'b1;
                end
            end
            S_LOAD_R: begin
                if (r_reg_addr == LAST_REG) begin
                    w_state_n     = S_RUN;
                    w_cpu_reset_n = 1'b0;
                    w_reg_addr_n  = 5'd0;
                end else begin
                    w_reg_we_n    = 1'b1;
                    w_reg_addr_n  = r_reg_addr + 5'd1;
                    w_reg_wdata_n = 32'(r_reg_addr + 5'd1);
                end
            end
            S_RUN: begin
                // Halt wins over a budget expiry in the same cycle.
                if (cpu_pc == halt_pc) begin
                    w_state_n     = S_CHECK;
                    w_cpu_stall_n = 1'b1;
                    w_chk_index_n = '0;
                end else if (r_cycles + CNT_W'(1) == BUDGET) begin
                    w_state_n      = S_DONE;
                    w_cycles_n     = BUDGET;
                    w_cpu_stall_n  = 1'b1;
                    w_busy_n       = 1'b0;
                    w_done_n       = 1'b1;
                    w_pass_n       = 1'b0;
                    w_timeout_n    = 1'b1;
                    w_fail_index_n = NO_FAIL;
                end else begin
                    w_cycles_n = r_cycles + CNT_W'(1);
                end
            end
            S_CHECK: begin
                if (reg_rdata != chk_value) begin
                    w_state_n      = S_DONE;
                    w_busy_n       = 1'b0;
                    w_done_n       = 1'b1;
                    w_pass_n       = 1'b0;
                    w_fail_index_n = r_chk_index;
                end else if (r_chk_index == LAST_CHK) begin
                    w_state_n      = S_DONE;
                    w_busy_n       = 1'b0;
                    w_done_n       = 1'b1;
                    w_pass_n       = 1'b1;
                    w_fail_index_n = NO_FAIL;
                end else begin
                    w_chk_index_n = r_chk_index + CW'(1);
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset to the idle image.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_prog_addr  <= '0;
            r_imem_we    <= 1'b0;
            r_reg_we     <= 1'b0;
            r_reg_addr   <= 5'd0;
            r_reg_wdata  <= 32'd0;
            r_cpu_reset  <= 1'b1;
            r_cpu_stall  <= 1'b0;
            r_chk_index  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
            r_fail_index <= '0;
            r_cycles     <= '0;
        end else begin
            r_state      <= w_state_n;
            r_prog_addr  <= w_prog_addr_n;
            r_imem_we    <= w_imem_we_n;
            r_reg_we     <= w_reg_we_n;
            r_reg_addr   <= w_reg_addr_n;
            r_reg_wdata  <= w_reg_wdata_n;
            r_cpu_reset  <= w_cpu_reset_n;
            r_cpu_stall  <= w_cpu_stall_n;
            r_chk_index  <= w_chk_index_n;
            r_busy       <= w_busy_n;
            r_done       <= w_done_n;
            r_pass       <= w_pass_n;
            r_timeout    <= w_timeout_n;
            r_fail_index <= w_fail_index_n;
            r_cycles     <= w_cycles_n;
        end
    end

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Scoreboard bench for cpu_test_sequencer with a toy CPU (PC steps by 4 when
// running) and a behavioural register file, program ROM and check table.
module tb_cpu_test_sequencer;
    localparam int NI = 4;
    localparam int NR = 4;
    localparam int NC = 2;
    localparam int MC = 8;
    localparam int AW = 2;
    localparam int KW = 2;

    logic clock = 1'b0, reset = 1'b1, start = 1'b0;
    logic [AW-1:0] prog_addr, imem_addr;
    logic [31:0] prog_data, imem_wdata, reg_wdata, reg_rdata;
    logic imem_we, reg_we, cpu_reset, cpu_stall, busy, done, pass, timeout;
    logic [4:0] reg_addr, chk_reg;
    logic [31:0] cpu_pc = 32'd0, halt_pc = 32'd0, chk_value;
    logic [KW-1:0] chk_index, fail_index;
    logic [15:0] cycles;

    logic [31:0] rom [NI];
    logic [31:0] regs [32];
    logic [4:0]  tbl_reg [NC];
    logic [31:0] tbl_val [NC];
    logic scramble = 1'b0;

    typedef struct { logic [31:0] a; logic [31:0] d; int off; } wr_t;
    typedef struct { bit ps; bit tmo; int fidx; int cyc; int chk; int run; int off; } res_t;
    wr_t  iq[$], rq[$];
    res_t resq[$];
    wr_t  mw;
    res_t mr;

    int checks = 0, failures = 0;
    int cyc = 0, s0 = 0;
    int runcnt = 0, chkcnt = 0;
    logic done_q = 1'b0;

    cpu_test_sequencer #(.N_REGISTERS(NR), .INSTR_MEM_SIZE(NI), .N_CHECKS(NC),
                         .MAX_CYCLES(MC), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .start(start),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .cpu_pc(cpu_pc), .halt_pc(halt_pc), .cpu_reset(cpu_reset), .cpu_stall(cpu_stall),
        .chk_index(chk_index), .chk_reg(chk_reg), .chk_value(chk_value),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .fail_index(fail_index), .cycles(cycles));

    always #5 clock = ~clock;

    assign prog_data = rom[prog_addr];
    assign reg_rdata = regs[reg_addr];
    assign chk_reg   = (int'(chk_index) < NC) ? tbl_reg[int'(chk_index)] : 5'd0;
    assign chk_value = (int'(chk_index) < NC) ? tbl_val[int'(chk_index)] : 32'd0;

    // Toy CPU and register file.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (cpu_reset) cpu_pc <= 32'd0;
        else if (!cpu_stall) cpu_pc <= cpu_pc + 32'd4;
        if (scramble) begin
            for (int i = 0; i < 32; i++) regs[i] <= $urandom;
        end else if (reg_we) begin
            regs[reg_addr] <= reg_wdata;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected writes/results as the DUT presents them.
    always @(negedge clock) begin
        if (!reset) begin
            if (imem_we === 1'b1) begin
                if (iq.size() == 0) chk("imem_unexpected", 1, 0);
                else begin
                    mw = iq.pop_front();
                    chk("imem_addr", 64'(imem_addr), 64'(mw.a));
                    chk("imem_data", 64'(imem_wdata), 64'(mw.d));
                    chk("imem_time", 64'(cyc - s0), 64'(mw.off));
                end
            end
            if (reg_we === 1'b1) begin
                if (rq.size() == 0) chk("reg_unexpected", 1, 0);
                else begin
                    mw = rq.pop_front();
                    chk("reg_addr", 64'(reg_addr), 64'(mw.a));
                    chk("reg_data", 64'(reg_wdata), 64'(mw.d));
                    chk("reg_time", 64'(cyc - s0), 64'(mw.off));
                end
            end
            if (busy === 1'b1 && cpu_stall === 1'b1) chkcnt <= chkcnt + 1;
            if (busy === 1'b1 && cpu_reset === 1'b0 && cpu_stall === 1'b0) runcnt <= runcnt + 1;
            if (done === 1'b1 && done_q !== 1'b1) begin
                if (resq.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    mr = resq.pop_front();
                    chk("pass", 64'(pass), 64'(mr.ps));
                    chk("timeout", 64'(timeout), 64'(mr.tmo));
                    chk("fail_index", 64'(fail_index), 64'(mr.fidx));
                    chk("cycles", 64'(cycles), 64'(mr.cyc));
                    chk("check_cycles", 64'(chkcnt), 64'(mr.chk));
                    chk("run_cycles", 64'(runcnt), 64'(mr.run));
                    chk("done_time", 64'(cyc - s0), 64'(mr.off));
                    chk("done_stall", 64'(cpu_stall), 1);
                    chk("done_busy", 64'(busy), 0);
                end
                chkcnt <= 0;
                runcnt <= 0;
            end
            done_q <= done;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: PC is 4*(n-1) in RUN cycle n; a loaded register r holds r.
    task automatic push_expect();
        res_t e;
        int h;
        for (int k = 0; k < NI; k++) iq.push_back('{a: 32'(k), d: rom[k], off: k});
        for (int j = 0; j < NR; j++) rq.push_back('{a: 32'(j), d: 32'(j), off: NI + j});
        if (halt_pc[1:0] == 2'b00 && (halt_pc / 4) < MC) begin
            h = int'(halt_pc / 4);
            e.tmo = 0; e.cyc = h; e.run = h + 1;
            e.ps = 1; e.fidx = NC; e.chk = NC;
            for (int i = 0; i < NC; i++) begin
                if (tbl_val[i] != 32'(tbl_reg[i])) begin
                    e.ps = 0; e.fidx = i; e.chk = i + 1;
                    break;
                end
            end
            e.off = NI + NR + 1 + h + e.chk;
        end else begin
            e.tmo = 1; e.ps = 0; e.fidx = NC; e.cyc = MC; e.run = MC; e.chk = 0;
            e.off = NI + NR + MC;
        end
        resq.push_back(e);
    endtask

    task automatic begin_run(input logic [31:0] hpc, input logic [4:0] r0, input logic [31:0] v0,
                             input logic [4:0] r1, input logic [31:0] v1);
        halt_pc = hpc;
        tbl_reg[0] = r0; tbl_val[0] = v0;
        tbl_reg[1] = r1; tbl_val[1] = v1;
        scramble = 1'b1;
        tick();
        scramble = 1'b0;
        start = 1'b1;
        s0 = cyc + 1;
        push_expect();
        tick();
        start = 1'b0;
        chk("start_clr_done", 64'(done), 0);
        chk("start_clr_pass", 64'(pass), 0);
        chk("start_clr_timeout", 64'(timeout), 0);
        chk("start_clr_fail", 64'(fail_index), 0);
        chk("start_clr_cycles", 64'(cycles), 0);
        chk("start_busy", 64'(busy), 1);
        chk("start_cpu_reset", 64'(cpu_reset), 1);
    endtask

    task automatic run(input logic [31:0] hpc, input logic [4:0] r0, input logic [31:0] v0,
                       input logic [4:0] r1, input logic [31:0] v1, input bit poke_run);
        int n;
        begin_run(hpc, r0, v0, r1, v1);
        if (poke_run) begin
            n = 0;
            while (cpu_reset !== 1'b0 && n < 50) begin tick(); n++; end
            if (n >= 50) chk("wait_run_bound", 0, 1);
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        n = 0;
        while (done !== 1'b1 && n < 100) begin tick(); n++; end
        if (n >= 100) chk("wait_done_bound", 0, 1);
        tick();
        tick();
        chk("done_held", 64'(done), 1);
        chk("stall_held", 64'(cpu_stall), 1);
    endtask

    initial begin
        int sel, r0, r1;
        logic [31:0] hpc, v0, v1;
        for (int i = 0; i < NI; i++) rom[i] = 32'd0;
        for (int i = 0; i < NC; i++) begin tbl_reg[i] = 5'd0; tbl_val[i] = 32'd0; end
        repeat (3) tick();
        chk("rst_cpu_reset", 64'(cpu_reset), 1);
        chk("rst_cpu_stall", 64'(cpu_stall), 0);
        chk("rst_imem_we", 64'(imem_we), 0);
        chk("rst_reg_we", 64'(reg_we), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_pass", 64'(pass), 0);
        chk("rst_timeout", 64'(timeout), 0);
        chk("rst_fail_index", 64'(fail_index), 0);
        chk("rst_cycles", 64'(cycles), 0);
        chk("rst_chk_index", 64'(chk_index), 0);
        chk("rst_prog_addr", 64'(prog_addr), 0);
        chk("rst_imem_addr", 64'(imem_addr), 0);
        chk("rst_reg_addr", 64'(reg_addr), 0);
        chk("rst_reg_wdata", 64'(reg_wdata), 0);
        reset = 1'b0;
        tick();

        // Load pattern and pass.
        rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;
        run(32'd12, 5'd1, 32'd1, 5'd3, 32'd3, 1'b0);
        // First mismatch on the second check.
        run(32'd12, 5'd1, 32'd1, 5'd2, 32'd7, 1'b0);
        // Timeout: PC never matches.
        run(32'h100, 5'd1, 32'd1, 5'd3, 32'd3, 1'b0);
        // Halt and timeout in the same RUN cycle.
        run(32'd28, 5'd2, 32'd2, 5'd0, 32'd0, 1'b0);
        // Mismatch on the first check, with a start pulse during RUN.
        run(32'd12, 5'd0, 32'd5, 5'd1, 32'd1, 1'b1);

        // Reset during LOAD_R.
        for (int i = 0; i < NI; i++) rom[i] = $urandom;
        begin_run(32'd8, 5'd1, 32'd1, 5'd2, 32'd2);
        sel = 0;
        while (reg_we !== 1'b1 && sel < 20) begin tick(); sel++; end
        if (sel >= 20) chk("wait_load_r_bound", 0, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_cpu_reset", 64'(cpu_reset), 1);
        chk("midrst_imem_we", 64'(imem_we), 0);
        chk("midrst_reg_we", 64'(reg_we), 0);
        chk("midrst_busy", 64'(busy), 0);
        chk("midrst_done", 64'(done), 0);
        chk("midrst_stall", 64'(cpu_stall), 0);
        chk("midrst_reg_addr", 64'(reg_addr), 0);
        iq.delete(); rq.delete(); resq.delete();
        repeat (3) tick();
        chk("idle_no_busy", 64'(busy), 0);

        // Minimum latency after reset: halt at the first RUN cycle.
        run(32'd0, 5'd3, 32'd3, 5'd1, 32'd1, 1'b0);

        // Randomized runs.
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < NI; i++) rom[i] = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 7) hpc = 32'(4 * $urandom_range(0, MC - 1));
            else if (sel < 9) hpc = 32'(4 * $urandom_range(MC, MC + 3));
            else hpc = 32'(4 * $urandom_range(0, MC - 1) + 2);
            r0 = $urandom_range(0, NR - 1);
            r1 = $urandom_range(0, NR - 1);
            v0 = ($urandom_range(0, 3) == 0) ? (32'(r0) ^ (32'd1 << $urandom_range(0, 31))) : 32'(r0);
            v1 = ($urandom_range(0, 3) == 0) ? (32'(r1) ^ (32'd1 << $urandom_range(0, 31))) : 32'(r1);
            run(hpc, 5'(r0), v0, 5'(r1), v1, 1'b0);
        end

        chk("queues_drained", 64'(iq.size() + rq.size() + resq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
